// File: rtl/wired_cdb_arbiter.sv
// rtl/wired_cdb_arbiter.sv - four-requester to two-bank CDB writeback arbiter
// Per-requester FIFOs feed a fixed-priority, age-overridden grant per ROB bank.
module wired_cdb_arbiter #(
    parameter int ROB_W      = 6,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic [3:0]            req_valid_i,
    output logic [3:0]            req_ready_o,
    input  logic [4*ROB_W-1:0]    req_rob_i,
    input  logic [4*DATA_W-1:0]   req_data_i,
    output logic [1:0]            cdb_valid_o,
    output logic [2*ROB_W-1:0]    cdb_rob_o,
    output logic [2*DATA_W-1:0]   cdb_data_o,
    output logic [3:0]            cdb_src_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int AGE_W = $clog2(STARVE_MAX + 1);

    logic [ROB_W-1:0]  mem_rob  [4][FIFO_DEPTH];
    logic [DATA_W-1:0] mem_data [4][FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr   [4];
    logic [PTR_W-1:0]  wr_ptr   [4];
    logic [CNT_W-1:0]  count    [4];
    logic [AGE_W-1:0]  age      [4];

    logic [3:0]        head_valid;
    logic [3:0]        urgent;
    logic [3:0]        push;
    logic [3:0]        grant;
    logic [ROB_W-1:0]  head_rob  [4];
    logic [DATA_W-1:0] head_data [4];
    logic [1:0]        bank_any;
    logic [1:0]        win_idx   [2];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            head_valid[i]  = (count[i] != '0);
            head_rob[i]    = mem_rob[i][rd_ptr[i]];
            head_data[i]   = mem_data[i][rd_ptr[i]];
            urgent[i]      = (age[i] == AGE_W'(STARVE_MAX));
            req_ready_o[i] = (count[i] < CNT_W'(FIFO_DEPTH));
            push[i]        = req_valid_i[i] & req_ready_o[i];
        end
    end

    // Scan from lowest priority upward so the last hit is the winner; the
    // urgent pass runs second so any urgent head overrides a non-urgent one.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_any[b] = 1'b0;
            win_idx[b]  = 2'd0;
            for (int i = 3; i >= 0; i--) begin
                if (head_valid[i] && (head_rob[i][0] == b[0]) && !urgent[i]) begin
                    bank_any[b] = 1'b1;
                    win_idx[b]  = 2'(i);
                end
            end
            for (int i = 3; i >= 0; i--) begin
                if (head_valid[i] && (head_rob[i][0] == b[0]) && urgent[i]) begin
                    bank_any[b] = 1'b1;
                    win_idx[b]  = 2'(i);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            grant[i] = head_valid[i] && (win_idx[head_rob[i][0]] == 2'(i));
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (push[i]) begin
                mem_rob[i][wr_ptr[i]]  <= req_rob_i[i*ROB_W +: ROB_W];
                mem_data[i][wr_ptr[i]] <= req_data_i[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
                age[i]    <= '0;
            end
        end else if (flush_i) begin
            for (int i = 0; i < 4; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
                age[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                if (grant[i]) rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                if (push[i] && !grant[i]) count[i] <= count[i] + CNT_W'(1);
                else if (!push[i] && grant[i]) count[i] <= count[i] - CNT_W'(1);
                if (!head_valid[i] || grant[i]) age[i] <= '0;
                else if (!urgent[i]) age[i] <= age[i] + AGE_W'(1);
            end
        end
    end

    // Payload registers keep their last beat while the valid bit is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_valid_o <= '0;
            cdb_rob_o   <= '0;
            cdb_data_o  <= '0;
            cdb_src_o   <= '0;
        end else if (flush_i) begin
            cdb_valid_o <= '0;
        end else begin
            cdb_valid_o <= bank_any;
            for (int b = 0; b < 2; b++) begin
                if (bank_any[b]) begin
                    cdb_rob_o[b*ROB_W +: ROB_W]    <= head_rob[win_idx[b]];
                    cdb_data_o[b*DATA_W +: DATA_W] <= head_data[win_idx[b]];
                    cdb_src_o[b*2 +: 2]            <= win_idx[b];
                end
            end
        end
    end

endmodule

// File: doc/wired_cdb_arbiter.md
Name: wired_cdb_arbiter

Overview:
- Arbitrates result writeback from the four execution requesters (ALU0, ALU1, LSU, MDU) onto the two CDB ports that feed the ROB and the issue-queue snoop ports.
- The ROB is split into two banks. CDB port b writes only ROB entries with rob_id[0]==b.
- Each requester has a small input FIFO. Priority is fixed ALU0 > ALU1 > LSU > MDU, with an aging override so the LSU and MDU are never starved.

Parameters:
- ROB_W, 6: ROB index width; bit 0 selects the bank.
- DATA_W, 32: result data width.
- FIFO_DEPTH, 2: per-requester input FIFO depth; power of 2, at least 2.
- STARVE_MAX, 4: lost arbitration cycles before a head becomes urgent; at least 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush_i  in  1  backend flush; discards all buffered results.
- req_valid_i  in  4  per requester; index 0=ALU0, 1=ALU1, 2=LSU, 3=MDU.
- req_ready_o  out  4  per-requester FIFO not full.
- req_rob_i  in  4 x ROB_W  ROB index of each result.
- req_data_i  in  4 x DATA_W  result data.
- cdb_valid_o  out  2  CDB port b carries a result this cycle.
- cdb_rob_o  out  2 x ROB_W  ROB index on port b.
- cdb_data_o  out  2 x DATA_W  data on port b.
- cdb_src_o  out  2 x 2  requester index granted on port b.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All FIFOs are emptied and all age counters are cleared.
  - cdb_valid_o=0, cdb_rob_o=0, cdb_data_o=0, cdb_src_o=0.
  - req_ready_o=4'b1111.
- Input handshake:
  - A push happens on a rising edge with req_valid_i[i] & req_ready_o[i].
  - req_ready_o[i] = (count_i < FIFO_DEPTH), computed from registered state only. A same-cycle pop does not raise ready.
  - A requester that drives valid while ready is low must hold its data; the block drops nothing.
- FIFO:
  - Circular buffer with wrap-around read and write pointers of width clog2(FIFO_DEPTH), plus a count of width clog2(FIFO_DEPTH)+1.
  - Simultaneous push and pop leaves the count unchanged.
- Arbitration is combinational on the FIFO heads, evaluated each cycle:
  - Candidates for bank b are the non-empty heads with head.rob[0]==b.
  - Urgent heads (age_i==STARVE_MAX) beat non-urgent heads.
  - Within the same urgency class, fixed priority applies: index 0 > 1 > 2 > 3.
  - Each head targets exactly one bank, so a requester is granted at most once per cycle, and both ports may fire in the same cycle.
- Output register:
  - On each edge, cdb_valid_o[b] <= bank b has any candidate.
  - When cdb_valid_o[b] loads 1, cdb_rob_o, cdb_data_o and cdb_src_o load the winner's values.
  - When cdb_valid_o[b] loads 0, the payload registers hold their previous values.
  - The granted head pops on the same edge.
- Latency:
  - Data pushed at edge t becomes the head after edge t if its FIFO was empty.
  - Such a result is visible on the CDB after edge t+1, i.e. a 1-cycle minimum latency.
  - There is no CDB backpressure: the ROB and snoop ports always accept.
- Aging, per requester:
  - age_i saturates at STARVE_MAX.
  - age_i increments when its head is valid and not granted.
  - age_i clears on a grant, or when its FIFO is empty.
- flush_i (synchronous, highest precedence over push and pop):
  - At the next edge all FIFOs empty, all ages clear and cdb_valid_o=0.
  - A push coincident with flush_i is discarded.
  - req_ready_o reads 4'b1111 the cycle after the flush.
- Reset mid-operation discards all in-flight data immediately, with no partial CDB beat.

Test Plan:
- Single result: LSU pushes rob=5, data=0xDEAD at edge t → after edge t+1, cdb_valid_o=2'b10, cdb_rob_o[1]=5, cdb_data_o[1]=0xDEAD, cdb_src_o[1]=2; cdb_valid_o returns to 0 after edge t+2.
- Bank conflict: ALU0 rob=4 and LSU rob=6 push at the same edge t → port 0 carries ALU0 (src 0) after edge t+1 and LSU (src 2) after edge t+2; port 1 stays idle.
- Dual issue: ALU0 rob=2 and MDU rob=3 push at edge t → after edge t+1 both ports are valid: port 0 carries src 0, port 1 carries src 3.
- Starvation (STARVE_MAX=4): ALU0 pushes even rob ids every cycle while MDU holds a single even rob head → MDU loses 4 cycles, then is granted port 0 on the 5th arbitration cycle; that cycle ALU0 is not granted on port 0.
- Full FIFO: ALU0 saturates bank 0 while LSU pushes 3 even-rob results back to back → req_ready_o[2] falls after 2 accepted pushes (the 3rd is stalled) and rises once the LSU head is granted via aging.
- Flush and reset: with 2 entries buffered in each FIFO, assert flush_i for one cycle → next cycle cdb_valid_o=0 and req_ready_o=4'hF, and no stale result appears afterwards; repeat with rst_n pulsed low asynchronously mid-cycle → outputs clear immediately.
